mult_booth_iter: RTL and testbench

MULT_BOOTH_ITER -- requirements
Module: mult_booth_iter

---
 rtl/mult_pkg.sv | 14 +
 rtl/booth_r4_enc.sv | 21 ++
 rtl/mult_booth_iter.sv | 137 +++++++++++++
 tb/tb_mult_booth_iter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states, Booth digits and
// the digit-count helper used to size the iteration.
package mult_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  typedef enum logic [2:0] {Zero, Pos1, Pos2, Neg1, Neg2} booth_digit_e;

  // Multiplier extended by one bit, then padded to even width: one digit per bit pair.
  function automatic int unsigned booth_iter(input int unsigned b_dw);
    return (b_dw + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 modified Booth encoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a digit in {0, +1, +2, -1, -2}.
module booth_r4_enc
  import mult_pkg::*;
(
  input  logic [2:0]   win_i,
  output booth_digit_e digit_o
);

  always_comb begin
    digit_o = Zero;
    unique case (win_i)
      3'b001, 3'b010: digit_o = Pos1;
      3'b011:         digit_o = Pos2;
      3'b100:         digit_o = Neg2;
      3'b101, 3'b110: digit_o = Neg1;
      default:        digit_o = Zero;
    endcase
  end

endmodule

// File: rtl/mult_booth_iter.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, signed or unsigned operands,
// valid/ready handshake on both sides with a registered, stable product.
module mult_booth_iter
  import mult_pkg::*;
#(
  parameter int unsigned A_DW = 8,
  parameter int unsigned B_DW = 8,
  parameter int unsigned C_DW = A_DW + B_DW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [A_DW-1:0] a_i,
  input  logic [B_DW-1:0] b_i,
  input  logic            signed_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [C_DW-1:0] c_o
);

  localparam int unsigned Iter = booth_iter(B_DW);
  localparam int unsigned BeW  = 2 * Iter;
  localparam int unsigned AccW = C_DW + 2;
  localparam int unsigned CntW = $clog2(Iter) + 1;

  localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [AccW-1:0] AccOne  = AccW'(1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] mcand_q, mcand_d;
  logic [BeW:0]    bwin_q, bwin_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [C_DW-1:0] c_q, c_d;

  booth_digit_e    digit;
  logic [AccW-1:0] pp;
  logic [AccW-1:0] acc_sum;

  // Window is always the low three bits; the multiplier shifts right by two each digit.
  booth_r4_enc u_enc (
    .win_i  (bwin_q[2:0]),
    .digit_o(digit)
  );

  // Multiplicand is pre-shifted by 2*i in its own register, so no variable shifter is needed.
  always_comb begin
    pp = '0;
    unique case (digit)
      Pos1:    pp = mcand_q;
      Pos2:    pp = mcand_q << 1;
      Neg1:    pp = ~mcand_q + AccOne;
      Neg2:    pp = ~(mcand_q << 1) + AccOne;
      default: pp = '0;
    endcase
  end

  assign acc_sum = acc_q + pp;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    bwin_d      = bwin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d    = StCalc;
          cnt_d      = '0;
          acc_d      = '0;
          mcand_d    = {{(AccW - A_DW){signed_i & a_i[A_DW-1]}}, a_i};
          bwin_d     = {{(BeW - B_DW){signed_i & b_i[B_DW-1]}}, b_i, 1'b0};
          in_ready_d = 1'b0;
        end
      end
      StCalc: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 2;
        bwin_d  = bwin_q >> 2;
        cnt_d   = cnt_q + CntOne;
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          c_d         = acc_sum[C_DW-1:0];
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      bwin_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      bwin_q      <= bwin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign c_o         = c_q;

endmodule

// File: tb/tb_mult_booth_iter.sv
// Directed bench for mult_booth_iter: 8x8 instance for products, latency, back-pressure and
// reset abort; 8x5 instance for the short-multiplier latency case.
module tb_mult_booth_iter;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  logic        iv5, ir5, s5, ov5, or5;
  logic [7:0]  a5;
  logic [4:0]  b5;
  logic [12:0] c5;

  int n_checks = 0;
  int n_pass   = 0;

  mult_booth_iter #(.A_DW(8), .B_DW(8)) dut8 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (iv8),
    .in_ready_o (ir8),
    .a_i        (a8),
    .b_i        (b8),
    .signed_i   (s8),
    .out_valid_o(ov8),
    .out_ready_i(or8),
    .c_o        (c8)
  );

  mult_booth_iter #(.A_DW(8), .B_DW(5)) dut5 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (iv5),
    .in_ready_o (ir5),
    .a_i        (a5),
    .b_i        (b5),
    .signed_i   (s5),
    .out_valid_o(ov5),
    .out_ready_i(or5),
    .c_o        (c5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Full transaction on the 8x8 instance; hold > 0 keeps out_ready low for that many DONE
  // cycles while offering different operands.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp, input int hold);
    int lat;
    @(negedge clk_i);
    check_eq({tag, "_rdy_idle"}, 32'(ir8), 32'd1);
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    @(posedge clk_i);
    #1 iv8 = 1'b0;
    check_eq({tag, "_rdy_calc"}, 32'(ir8), 32'd0);
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk_i);
      #1 lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    check_eq({tag, "_prod"}, 32'(c8), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; s8 = 1'b0;
      @(posedge clk_i);
      #1;
      check_eq({tag, "_hold_valid"}, 32'(ov8), 32'd1);
      check_eq({tag, "_hold_prod"}, 32'(c8), 32'(exp));
      check_eq({tag, "_hold_rdy"}, 32'(ir8), 32'd0);
    end
    @(negedge clk_i);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk_i);
    #1 or8 = 1'b0;
    check_eq({tag, "_post_rdy"}, 32'(ir8), 32'd1);
    check_eq({tag, "_post_valid"}, 32'(ov8), 32'd0);
    check_eq({tag, "_post_prod"}, 32'(c8), 32'(exp));
  endtask

  initial begin
    int lat;
    bit seen;
    rst_ni = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b0;
    iv5 = 1'b0; a5 = '0; b5 = '0; s5 = 1'b0; or5 = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_rdy", 32'(ir8), 32'd1);
    check_eq("rst_valid", 32'(ov8), 32'd0);
    check_eq("rst_prod", 32'(c8), 32'd0);

    // Release mid-cycle so run8 accepts on the very first edge with reset high.
    @(posedge clk_i);
    #2 rst_ni = 1'b1;

    run8("s_min_min", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    run8("u_ff_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    run8("s_m1_7f",   8'hFF, 8'h7F, 1'b1, 16'hFF81, 0);
    run8("u_80_80",   8'h80, 8'h80, 1'b0, 16'h4000, 0);
    run8("s_7f_7f",   8'h7F, 8'h7F, 1'b1, 16'h3F01, 0);
    run8("s_80_7f",   8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    run8("u_zero",    8'h00, 8'h55, 1'b0, 16'h0000, 0);
    run8("u_12_10",   8'd12, 8'd10, 1'b0, 16'h0078, 0);
    run8("s_bp_5_m3", 8'd5,   8'hFD, 1'b1, 16'hFFF1, 10);

    // Short multiplier: 3 Booth digits.
    @(negedge clk_i);
    check_eq("b5_rdy_idle", 32'(ir5), 32'd1);
    a5 = 8'd200; b5 = 5'd31; s5 = 1'b0; iv5 = 1'b1;
    @(posedge clk_i);
    #1 iv5 = 1'b0;
    lat = 0;
    while (!ov5 && lat < 20) begin
      @(posedge clk_i);
      #1 lat++;
    end
    check_eq("b5_latency", 32'(lat), 32'd3);
    check_eq("b5_prod", 32'(c5), 32'h1838);
    @(negedge clk_i);
    or5 = 1'b1;
    @(posedge clk_i);
    #1 or5 = 1'b0;
    check_eq("b5_post_valid", 32'(ov5), 32'd0);

    // Abort in the second CALC cycle.
    @(negedge clk_i);
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b1; iv8 = 1'b1;
    @(posedge clk_i);
    #1 iv8 = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("abort_rdy", 32'(ir8), 32'd1);
    check_eq("abort_valid", 32'(ov8), 32'd0);
    check_eq("abort_prod", 32'(c8), 32'd0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1 if (ov8) seen = 1'b1;
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);
    run8("s_3_m4", 8'd3, 8'hFC, 1'b1, 16'hFFF4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
